// File: rtl/hazard_pkg.sv
// Shared constants and types for the register hazard scoreboard.
package hazard_pkg;

    // Default register address width (2**HZ_REG_W architectural registers).
    localparam int unsigned HZ_REG_W   = 5;
    // Default maximum result latency in cycles.
    localparam int unsigned HZ_MAX_LAT = 4;
    // Counter / latency field width able to hold 0..HZ_MAX_LAT.
    localparam int unsigned HZ_LAT_W   = $clog2(HZ_MAX_LAT + 1);

    typedef logic [HZ_LAT_W-1:0] lat_t;
    typedef logic [HZ_REG_W-1:0] reg_addr_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard interface: issue request, source operands and hazard results.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W   = HZ_REG_W,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MAX_LAT = HZ_MAX_LAT
);
    localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);

    logic                              issue_valid;
    logic                              issue_wr;
    logic [REG_W-1:0]                  issue_rd;
    logic [LAT_W-1:0]                  issue_lat;
    logic [NUM_SRC-1:0][REG_W-1:0]     src_addr;
    logic [NUM_SRC-1:0]                src_used;
    logic                              flush;
    logic                              stall;
    logic [NUM_SRC-1:0]                fwd;
    logic [REG_W:0]                    busy_count;

    // Decode stage side.
    modport master (
        output issue_valid, issue_wr, issue_rd, issue_lat, src_addr, src_used, flush,
        input  stall, fwd, busy_count
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_wr, issue_rd, issue_lat, src_addr, src_used, flush,
        output stall, fwd, busy_count
    );

endinterface

// File: rtl/sb_entry.sv
// One pending-write down-counter for a single architectural register.
module sb_entry
    import hazard_pkg::*;
#(
    parameter int unsigned LAT_W = HZ_LAT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_lat,
    output logic [LAT_W-1:0] o_cnt
);
    logic [LAT_W-1:0] r_cnt;

    // Load a new latency on accepted issue, otherwise count down to zero.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_lat;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - LAT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register result countdown, RAW/WAW/writeback-slot
// stall generation, bypass selects and a pending-write count.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W     = HZ_REG_W,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned MAX_LAT   = HZ_MAX_LAT,
    parameter int unsigned SINGLE_WB = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    hazard_scoreboard_if.slave  sb_if
);
    localparam int unsigned LAT_W  = $clog2(MAX_LAT + 1);
    localparam int unsigned NREG   = 2 ** REG_W;
    localparam int unsigned BUSY_W = REG_W + 1;

    logic [LAT_W-1:0]   w_cnt [NREG];
    logic [LAT_W-1:0]   w_lat_eff;
    logic               w_dst_ok;
    logic               w_raw;
    logic               w_waw;
    logic               w_slot_hit;
    logic               w_wb;
    logic               w_stall;
    logic               w_accept;
    logic               w_load_en;
    logic [NUM_SRC-1:0] w_fwd;
    logic [BUSY_W-1:0]  w_busy;

    // Register 0 never has a pending write.
    assign w_cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_load  (w_load_en && (sb_if.issue_rd == REG_W'(r))),
            .i_lat   (w_lat_eff),
            .o_cnt   (w_cnt[r])
        );
    end

    // Saturate the requested latency to the deepest counter value.
    always_comb begin
        w_lat_eff = sb_if.issue_lat;
        if (sb_if.issue_lat > LAT_W'(MAX_LAT)) begin
            w_lat_eff = LAT_W'(MAX_LAT);
        end
    end

    // RAW detection and bypass selects from pre-issue counters.
    always_comb begin
        w_raw = 1'b0;
        w_fwd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sb_if.src_used[i] && (sb_if.src_addr[i] != '0)) begin
                if (w_cnt[sb_if.src_addr[i]] > LAT_W'(1)) begin
                    w_raw = 1'b1;
                end
                if (w_cnt[sb_if.src_addr[i]] == LAT_W'(1)) begin
                    w_fwd[i] = 1'b1;
                end
            end
        end
    end

    // WAW ordering and single-writeback-port slot conflict.
    always_comb begin
        w_dst_ok   = sb_if.issue_wr && (sb_if.issue_rd != '0);
        w_waw      = w_dst_ok && (w_cnt[sb_if.issue_rd] > w_lat_eff);
        w_slot_hit = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (w_cnt[r] == w_lat_eff) begin
                w_slot_hit = 1'b1;
            end
        end
        // A zero-latency issue creates no entry, so it cannot claim a writeback slot.
        w_wb = (SINGLE_WB != 0) && w_dst_ok && (w_lat_eff != '0) && w_slot_hit;
    end

    // Stall and accept; flush kills the decode instruction without touching state.
    always_comb begin
        w_stall   = sb_if.issue_valid && (w_raw || w_waw || w_wb);
        w_accept  = sb_if.issue_valid && !w_stall && !sb_if.flush;
        w_load_en = w_accept && w_dst_ok && (w_lat_eff != '0);
    end

    // Count registers with a pending write.
    always_comb begin
        w_busy = '0;
        for (int r = 1; r < NREG; r++) begin
            if (w_cnt[r] != '0) begin
                w_busy = w_busy + BUSY_W'(1);
            end
        end
    end

    assign sb_if.stall      = w_stall;
    assign sb_if.fwd        = w_fwd;
    assign sb_if.busy_count = w_busy;

endmodule
